alu_daa_pipe: RTL and testbench

Two-stage registered ALU with decimal adjust for the 6502 datapath. Consumes the A-input and B-input register outputs and the carry-in. Stage 1 produces the binary result for the adder hold register plus the ACR/AVR flags for the status register. Stage 2 produces the decimal-adjusted value that the accumulator loads. The block accepts one operation per cycle and tracks each stage's result with a valid flag.

---
 rtl/alu_daa_pipe_pkg.sv | 15 +
 rtl/alu_daa_pipe_if.sv | 31 +++
 rtl/alu_daa_pipe_decimal_adjust.sv | 30 +++
 rtl/alu_daa_pipe.sv | 131 +++++++++++++
 tb/tb_alu_daa_pipe.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_daa_pipe_pkg.sv
// Shared constants for the two-stage 6502 ALU / decimal-adjust pipeline.
package alu_pkg;

    localparam int ALU_OP_W = 3;

    localparam logic [ALU_OP_W-1:0] ALU_OP_SUM = 3'd0;
    localparam logic [ALU_OP_W-1:0] ALU_OP_AND = 3'd1;
    localparam logic [ALU_OP_W-1:0] ALU_OP_EOR = 3'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OP_OR  = 3'd3;
    localparam logic [ALU_OP_W-1:0] ALU_OP_SR  = 3'd4;

    localparam logic [7:0] BCD_ADJ_LO = 8'h06;
    localparam logic [7:0] BCD_ADJ_HI = 8'h60;

endpackage

// File: rtl/alu_daa_pipe_if.sv
// Operand/result bundle between the datapath registers and alu_daa_pipe.
interface alu_daa_pipe_if;
    import alu_pkg::*;

    logic                START;
    logic [ALU_OP_W-1:0] OP;
    logic [7:0]          AI_DATA;
    logic [7:0]          BI_DATA;
    logic                CARRY_IN;
    logic                DAA;
    logic                DSA;
    logic [7:0]          ALU_DATA;
    logic                ACR;
    logic                AVR;
    logic                HC;
    logic                ADD_VALID;
    logic [7:0]          DAA_DATA;
    logic                DAA_CARRY;
    logic                DAA_VALID;

    modport master (
        output START, OP, AI_DATA, BI_DATA, CARRY_IN, DAA, DSA,
        input  ALU_DATA, ACR, AVR, HC, ADD_VALID, DAA_DATA, DAA_CARRY, DAA_VALID
    );

    modport slave (
        input  START, OP, AI_DATA, BI_DATA, CARRY_IN, DAA, DSA,
        output ALU_DATA, ACR, AVR, HC, ADD_VALID, DAA_DATA, DAA_CARRY, DAA_VALID
    );

endinterface

// File: rtl/alu_daa_pipe_decimal_adjust.sv
// Combinational BCD corrector for stage 2; only built when ALU_DECIMAL_EN is defined.
`ifdef ALU_DECIMAL_EN
module alu_decimal_adjust
    import alu_pkg::*;
(
    input  logic [7:0] r,
    input  logic       hc,
    input  logic       acr,
    input  logic       daa,
    input  logic       dsa,
    output logic [7:0] adj_data,
    output logic       adj_carry
);

    always_comb begin
        adj_data  = r;
        adj_carry = acr;
        if (daa) begin
            if (hc || (r[3:0] > 4'd9)) adj_data = adj_data + BCD_ADJ_LO;
            if (acr || (r > 8'h99))    adj_data = adj_data + BCD_ADJ_HI;
            adj_carry = acr || (r > 8'h99);
        end else if (dsa) begin
            // A cleared carry is a borrow out of that nibble.
            if (!hc)  adj_data = adj_data - BCD_ADJ_LO;
            if (!acr) adj_data = adj_data - BCD_ADJ_HI;
        end
    end

endmodule
`endif

// File: rtl/alu_daa_pipe.sv
// Two-stage ALU: stage 1 binary result and flags, stage 2 decimal adjust.
// Macro ALU_DECIMAL_EN enables the BCD corrector; otherwise stage 2 is a plain register.
module alu_daa_pipe
    import alu_pkg::*;
(
    input  logic          CLK,
    input  logic          RST_N,
    alu_daa_pipe_if.slave bus
);

    logic [7:0] alu_data_q, alu_data_d;
    logic       acr_q, acr_d;
    logic       avr_q, avr_d;
    logic       hc_q, hc_d;
    logic       add_valid_q, add_valid_d;
    logic       dec_add_q, dec_add_d;
    logic       dec_sub_q, dec_sub_d;
    logic [7:0] daa_data_q, daa_data_d;
    logic       daa_carry_q, daa_carry_d;
    logic       daa_valid_q, daa_valid_d;

    logic [8:0] sum9;
    logic [4:0] sum_lo;
    logic [7:0] adj_data;
    logic       adj_carry;

    always_comb begin
        sum9   = {1'b0, bus.AI_DATA} + {1'b0, bus.BI_DATA} + {8'd0, bus.CARRY_IN};
        sum_lo = {1'b0, bus.AI_DATA[3:0]} + {1'b0, bus.BI_DATA[3:0]} + {4'd0, bus.CARRY_IN};

        alu_data_d  = alu_data_q;
        acr_d       = acr_q;
        avr_d       = avr_q;
        hc_d        = hc_q;
        dec_add_d   = dec_add_q;
        dec_sub_d   = dec_sub_q;
        add_valid_d = bus.START;

        if (bus.START) begin
            alu_data_d = 8'h00;
            acr_d      = 1'b0;
            avr_d      = 1'b0;
            hc_d       = 1'b0;
            dec_add_d  = 1'b0;
            dec_sub_d  = 1'b0;
            case (bus.OP)
                ALU_OP_SUM: begin
                    alu_data_d = sum9[7:0];
                    acr_d      = sum9[8];
                    hc_d       = sum_lo[4];
                    avr_d      = (bus.AI_DATA[7] == bus.BI_DATA[7]) &&
                                 (sum9[7] != bus.AI_DATA[7]);
                    // Add adjust takes priority if both requests arrive together.
                    dec_add_d  = bus.DAA;
                    dec_sub_d  = bus.DSA && !bus.DAA;
                end
                ALU_OP_AND: alu_data_d = bus.AI_DATA & bus.BI_DATA;
                ALU_OP_EOR: alu_data_d = bus.AI_DATA ^ bus.BI_DATA;
                ALU_OP_OR:  alu_data_d = bus.AI_DATA | bus.BI_DATA;
                ALU_OP_SR: begin
                    alu_data_d = {bus.CARRY_IN, bus.AI_DATA[7:1]};
                    acr_d      = bus.AI_DATA[0];
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_DECIMAL_EN
    alu_decimal_adjust u_adj (
        .r         (alu_data_q),
        .hc        (hc_q),
        .acr       (acr_q),
        .daa       (dec_add_q),
        .dsa       (dec_sub_q),
        .adj_data  (adj_data),
        .adj_carry (adj_carry)
    );
`else
    logic unused_dec_flags;
    assign unused_dec_flags = dec_add_q ^ dec_sub_q;
    assign adj_data         = alu_data_q;
    assign adj_carry        = acr_q;
`endif

    always_comb begin
        daa_data_d  = daa_data_q;
        daa_carry_d = daa_carry_q;
        daa_valid_d = add_valid_q;
        if (add_valid_q) begin
            daa_data_d  = adj_data;
            daa_carry_d = adj_carry;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            alu_data_q  <= 8'h00;
            acr_q       <= 1'b0;
            avr_q       <= 1'b0;
            hc_q        <= 1'b0;
            add_valid_q <= 1'b0;
            dec_add_q   <= 1'b0;
            dec_sub_q   <= 1'b0;
            daa_data_q  <= 8'h00;
            daa_carry_q <= 1'b0;
            daa_valid_q <= 1'b0;
        end else begin
            alu_data_q  <= alu_data_d;
            acr_q       <= acr_d;
            avr_q       <= avr_d;
            hc_q        <= hc_d;
            add_valid_q <= add_valid_d;
            dec_add_q   <= dec_add_d;
            dec_sub_q   <= dec_sub_d;
            daa_data_q  <= daa_data_d;
            daa_carry_q <= daa_carry_d;
            daa_valid_q <= daa_valid_d;
        end
    end

    assign bus.ALU_DATA  = alu_data_q;
    assign bus.ACR       = acr_q;
    assign bus.AVR       = avr_q;
    assign bus.HC        = hc_q;
    assign bus.ADD_VALID = add_valid_q;
    assign bus.DAA_DATA  = daa_data_q;
    assign bus.DAA_CARRY = daa_carry_q;
    assign bus.DAA_VALID = daa_valid_q;

endmodule

// File: tb/tb_alu_daa_pipe.sv
// Randomized bench for alu_daa_pipe against an arithmetic reference model.
module tb_alu_daa_pipe;
    import alu_pkg::*;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    alu_daa_pipe_if bus ();

    alu_daa_pipe dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Currently applied stimulus.
    bit cur_st, cur_c, cur_d, cur_s;
    int cur_op, cur_a, cur_b;

    // Expected architectural state.
    int m_alu, m_daa;
    bit m_acr, m_avr, m_hc, m_av, m_dadd, m_dsub, m_dc, m_dv;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic ref_s1(input int op, input int a, input int b, input int c,
                          output int data, output bit acr, output bit avr, output bit hc);
        int s, sa, sb;
        data = 0; acr = 0; avr = 0; hc = 0;
        case (op)
            0: begin
                s   = a + b + c;
                data = s % 256;
                acr = (s > 255);
                hc  = ((a % 16) + (b % 16) + c) > 15;
                sa  = (a > 127) ? a - 256 : a;
                sb  = (b > 127) ? b - 256 : b;
                avr = ((sa + sb + c) > 127) || ((sa + sb + c) < -128);
            end
            1: data = a & b;
            2: data = a ^ b;
            3: data = a | b;
            4: begin
                data = c * 128 + a / 2;
                acr  = (a % 2) == 1;
            end
            default: ;
        endcase
    endtask

    task automatic ref_s2(input int r, input bit hc, input bit acr, input bit dadd, input bit dsub,
                          output int data, output bit carry);
        int v;
        v = r;
        carry = acr;
`ifdef ALU_DECIMAL_EN
        if (dadd) begin
            if (hc || (r % 16) > 9) v = v + 6;
            if (acr || r > 153)     v = v + 96;
            carry = acr || (r > 153);
        end else if (dsub) begin
            if (!hc)  v = v - 6;
            if (!acr) v = v - 96;
        end
`endif
        data = (v + 512) % 256;
    endtask

    task automatic model_reset();
        m_alu = 0; m_daa = 0;
        m_acr = 0; m_avr = 0; m_hc = 0; m_av = 0;
        m_dadd = 0; m_dsub = 0; m_dc = 0; m_dv = 0;
    endtask

    task automatic drive(input bit st, input int op, input int a, input int b,
                         input bit c, input bit d, input bit s);
        cur_st = st; cur_op = op; cur_a = a; cur_b = b; cur_c = c; cur_d = d; cur_s = s;
        bus.START    = st;
        bus.OP       = op[2:0];
        bus.AI_DATA  = a[7:0];
        bus.BI_DATA  = b[7:0];
        bus.CARRY_IN = c;
        bus.DAA      = d;
        bus.DSA      = s;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_s1"}, {20'd0, bus.ADD_VALID, bus.ACR, bus.AVR, bus.HC, bus.ALU_DATA},
                          {20'd0, m_av, m_acr, m_avr, m_hc, m_alu[7:0]});
        chk({tag, "_s2"}, {22'd0, bus.DAA_VALID, bus.DAA_CARRY, bus.DAA_DATA},
                          {22'd0, m_dv, m_dc, m_daa[7:0]});
    endtask

    task automatic tick(input string tag);
        int d;
        bit c;
        @(posedge CLK);
        m_dv = m_av;
        if (m_av) begin
            ref_s2(m_alu, m_hc, m_acr, m_dadd, m_dsub, d, c);
            m_daa = d;
            m_dc  = c;
        end
        m_av = cur_st;
        if (cur_st) begin
            ref_s1(cur_op, cur_a, cur_b, int'(cur_c), m_alu, m_acr, m_avr, m_hc);
            m_dadd = (cur_op == 0) && cur_d;
            m_dsub = (cur_op == 0) && cur_s && !cur_d;
        end
        #1;
        check_all(tag);
    endtask

    logic [7:0] e_tp1, e_tp2, e_tp3;
    logic       c_tp2;

    initial begin
`ifdef ALU_DECIMAL_EN
        e_tp1 = 8'h47; e_tp2 = 8'h05; c_tp2 = 1'b1; e_tp3 = 8'h09;
`else
        e_tp1 = 8'h41; e_tp2 = 8'h9F; c_tp2 = 1'b0; e_tp3 = 8'h0F;
`endif
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        #12;
        chk("reset_outputs", {bus.ADD_VALID, bus.DAA_VALID, bus.ACR, bus.AVR, bus.HC, bus.DAA_CARRY,
                              bus.ALU_DATA, bus.DAA_DATA}, 22'd0);
        check_all("reset");
        RST_N = 1'b1;

        // BCD add with half carry.
        drive(1, 0, 'h19, 'h28, 0, 1, 0);
        tick("tp1_a");
        chk("tp1_alu", {bus.ALU_DATA, bus.HC, bus.ACR}, {8'h41, 1'b1, 1'b0});
        drive(0, 0, 0, 0, 0, 0, 0);
        tick("tp1_b");
        chk("tp1_daa", {bus.DAA_VALID, bus.DAA_DATA, bus.DAA_CARRY}, {1'b1, e_tp1, 1'b0});

        // BCD add with decimal carry out.
        drive(1, 0, 'h58, 'h46, 1, 1, 0);
        tick("tp2_a");
        chk("tp2_alu", {bus.ALU_DATA, bus.HC}, {8'h9F, 1'b0});
        drive(0, 0, 0, 0, 0, 0, 0);
        tick("tp2_b");
        chk("tp2_daa", {bus.DAA_DATA, bus.DAA_CARRY}, {e_tp2, c_tp2});

        // BCD subtract 0x10 - 0x01.
        drive(1, 0, 'h10, 'hFE, 1, 0, 1);
        tick("tp3_a");
        chk("tp3_alu", {bus.ALU_DATA, bus.ACR, bus.HC}, {8'h0F, 1'b1, 1'b0});
        drive(0, 0, 0, 0, 0, 0, 0);
        tick("tp3_b");
        chk("tp3_daa", {bus.DAA_DATA, bus.DAA_CARRY}, {e_tp3, 1'b1});

        // Signed overflow, then shift right through carry.
        drive(1, 0, 'h50, 'h50, 0, 0, 0);
        tick("tp4_sum");
        chk("tp4_avr", {bus.ALU_DATA, bus.AVR, bus.ACR}, {8'hA0, 1'b1, 1'b0});
        drive(1, 4, 'h81, 'h00, 1, 0, 0);
        tick("tp4_sr");
        chk("tp4_sr_val", {bus.ALU_DATA, bus.ACR}, {8'hC0, 1'b1});

        // Five back-to-back ops, one per OP code; DAA ignored on non-SUM ops.
        drive(1, 0, 'h37, 'h45, 0, 1, 0); tick("b2b_sum");
        drive(1, 1, 'hF0, 'h3C, 1, 1, 1); tick("b2b_and");
        chk("b2b_valid0", {bus.ADD_VALID, bus.DAA_VALID}, 2'b11);
        drive(1, 2, 'hF0, 'h3C, 0, 1, 0); tick("b2b_eor");
        drive(1, 3, 'hF0, 'h3C, 0, 0, 1); tick("b2b_or");
        drive(1, 4, 'h02, 'h00, 0, 1, 0); tick("b2b_sr");
        drive(0, 0, 0, 0, 0, 0, 0);       tick("b2b_drain");
        chk("b2b_valid1", {bus.ADD_VALID, bus.DAA_VALID}, 2'b01);

        // Reserved op code clears result and flags.
        drive(1, 6, 'hFF, 'hFF, 1, 1, 1);
        tick("rsvd");
        chk("rsvd_val", {bus.ALU_DATA, bus.ACR, bus.AVR, bus.HC}, 11'd0);
        drive(0, 0, 0, 0, 0, 0, 0);
        tick("rsvd_b");

        // Reset between stages loses the op.
        drive(1, 0, 'h99, 'h01, 0, 1, 0);
        tick("mid_a");
        drive(0, 0, 0, 0, 0, 0, 0);
        RST_N = 1'b0;
        #1;
        model_reset();
        chk("mid_rst", {bus.ADD_VALID, bus.DAA_VALID, bus.ALU_DATA, bus.DAA_DATA,
                        bus.ACR, bus.AVR, bus.HC, bus.DAA_CARRY}, 22'd0);
        check_all("mid_rst");
        #2;
        RST_N = 1'b1;
        drive(1, 0, 'h12, 'h34, 0, 1, 0);
        tick("post_a");
        chk("post_alu", {bus.ADD_VALID, bus.ALU_DATA}, {1'b1, 8'h46});
        drive(0, 0, 0, 0, 0, 0, 0);
        tick("post_b");

        // Random streams including bubbles (hold) and all op codes.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(3) != 0), int'($urandom_range(7)),
                  int'($urandom_range(255)), int'($urandom_range(255)),
                  1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
            tick("rand");
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        tick("end_a");
        tick("end_b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
